// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared state encodings and sizing helpers for the floating-adder step units
package fp_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Number of chunks an operand is split into
    function automatic int num_chunks(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // Chunk index width; a single-chunk operand still gets a 1-bit index
    function automatic int chunk_idx_w(input int width, input int bits_per_cycle);
        int n;
        n = width / bits_per_cycle;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_ctrl_incrementor_inc_chunk.sv
// rtl/seq_ctrl_incrementor_inc_chunk.sv - combinational B-bit ripple increment/decrement step
module inc_chunk #(
    parameter int B = 1
) (
    input  logic [B-1:0] chunk,
    input  logic         c_in,
    input  logic         dec,
    output logic [B-1:0] chunk_out,
    output logic         c_out
);

    logic c_ripple;

    // Ripple the carry (inc) or borrow (dec) from the chunk LSB upwards
    always_comb begin
        c_ripple  = c_in;
        chunk_out = '0;
        for (int i = 0; i < B; i++) begin
            chunk_out[i] = chunk[i] ^ c_ripple;
            c_ripple     = dec ? (c_ripple & ~chunk[i]) : (c_ripple & chunk[i]);
        end
        c_out = c_ripple;
    end

endmodule

// File: rtl/seq_ctrl_incrementor.sv
// rtl/seq_ctrl_incrementor.sv - multi-cycle chunked controlled incrementor with valid/ready handshakes
module seq_ctrl_incrementor
    import fp_add_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SATURATE       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             En,
    input  logic             Dec,
    input  logic [WIDTH-1:0] Z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NUM_CHUNKS  = num_chunks(WIDTH, BITS_PER_CYCLE);
    localparam int CHUNK_IDX_W = chunk_idx_w(WIDTH, BITS_PER_CYCLE);
    localparam logic [CHUNK_IDX_W-1:0] LAST_IDX = CHUNK_IDX_W'(NUM_CHUNKS - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("seq_ctrl_incrementor: WIDTH must be at least 2");
    end
    if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("seq_ctrl_incrementor: BITS_PER_CYCLE must divide WIDTH");
    end

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       work_q, work_d;
    logic                   dec_q, dec_d;
    logic                   carry_q, carry_d;
    logic [CHUNK_IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   cout_q, cout_d;
    logic                   ovf_q, ovf_d;

    logic [BITS_PER_CYCLE-1:0] chunk_in;
    logic [BITS_PER_CYCLE-1:0] chunk_out;
    logic                      c_next;
    logic [WIDTH-1:0]          work_step;
    logic                      accept;
    logic                      last_chunk;

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == ST_HOLD);
    assign last_chunk = (idx_q == LAST_IDX);
    assign Out        = out_q;
    assign Cout       = cout_q;
    assign Ovf        = ovf_q;

    // Pick the chunk addressed by the current index out of the working register
    always_comb begin
        chunk_in = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (idx_q == CHUNK_IDX_W'(k)) begin
                chunk_in = work_q[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
            end
        end
    end

    inc_chunk #(
        .B(BITS_PER_CYCLE)
    ) u_inc_chunk (
        .chunk     (chunk_in),
        .c_in      (carry_q),
        .dec       (dec_q),
        .chunk_out (chunk_out),
        .c_out     (c_next)
    );

    // Write the stepped chunk back; bits outside the current chunk are untouched
    always_comb begin
        work_step = work_q;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (idx_q == CHUNK_IDX_W'(k)) begin
                work_step[k*BITS_PER_CYCLE +: BITS_PER_CYCLE] = chunk_out;
            end
        end
    end

    // Handshake FSM: accept, walk chunks until the carry dies, then hold the result
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dec_d   = dec_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if ((state_q == ST_HOLD) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    work_d  = Z;
                    dec_d   = Dec;
                    carry_d = En;
                    idx_d   = '0;
                    if (En) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                        out_d   = Z;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                work_d  = work_step;
                carry_d = c_next;
                if (!c_next || last_chunk) begin
                    state_d = ST_HOLD;
                    cout_d  = c_next;
                    // RUN is only entered with En=1, so overflow is the final carry
                    ovf_d   = c_next;
                    if (c_next && (SATURATE != 0)) begin
                        out_d = dec_q ? '0 : '1;
                    end else begin
                        out_d = work_step;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            dec_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dec_q   <= dec_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
